prog_launch_ctrl: RTL and testbench
===================================

// Module: prog_launch_ctrl
// PURPOSE
//  Sequencer in front of the program counter. Counts Start pulses, loads the entry
//  address of program 1..NUM_PROGS into the PC, and gates PC advance while idle.
//  Holds Run until the core raises Done, then returns to idle for the next pulse.
//  Sits between the testbench/top-level Start/Done handshake and the PC load/enable inputs.
// PARAMETERS
//  L          10   PC width (bits)
//  NUM_PROGS  3    number of programs; legal range 1..3
//  PROG1_ADDR 0    entry address of program 1
//  PROG2_ADDR 190  entry address of program 2
//  PROG3_ADDR 639  entry address of program 3
//  CYC_W      16   cycle-counter width
// PORTS
//  Clk        in   1      clock; all state changes on posedge
//  Reset      in   1      asynchronous, active-high reset
//  Start      in   1      launch strobe, level; launch is on its falling edge
//  Done       in   1      core signals the current program has finished; sampled only in RUN
//  PCLoad     out  1      one-cycle pulse: PC <= PCLoadAddr
//  PCLoadAddr out  L      entry address for the current program
//  Run        out  1      PC/core enable; PC must hold while this is 0
//  ProgIdx    out  2      program number launched (0 = none yet, then 1..NUM_PROGS)
//  Busy       out  1      1 in LOAD, RUN and FIN
//  AllDone    out  1      sticky: program NUM_PROGS has finished
//  CycleCount out  CYC_W  Run cycles of the current/last program
// BEHAVIOUR
//  Reset values (async): all outputs 0; state IDLE; start_r 0; ProgIdx 0; PCLoadAddr 0.
//  Edge detect: start_r <= Start each cycle.
//    rise = Start & ~start_r; fall = ~Start & start_r.
//  FSM states: IDLE, ARMED, LOAD, RUN, FIN. All outputs are registered (Moore).
//    IDLE:  on rise with ProgIdx < NUM_PROGS -> ARMED and ProgIdx++.
//           On rise with ProgIdx == NUM_PROGS: ignored, stay IDLE.
//    ARMED: on fall -> LOAD.
//           PCLoadAddr <= PROGn_ADDR for n = ProgIdx. Out-of-range index yields 0.
//    LOAD:  PCLoad=1 for exactly this one cycle -> RUN.
//    RUN:   Run=1. On Done=1 -> FIN.
//    FIN:   Run=0 for one cycle.
//           AllDone <= 1 if ProgIdx == NUM_PROGS. Then -> IDLE.
//  Latency:
//    fall sampled in cycle N -> PCLoad=1 in N+1 -> Run=1 from N+2.
//    Done sampled in cycle M -> Run=0 from M+1.
//  Ignored inputs:
//    Start edges in LOAD, RUN and FIN are ignored; they are neither counted nor queued.
//    Done outside RUN is ignored.
//    Done already high when RUN is entered ends the program after 1 Run cycle.
//  Start pulse widths:
//    Start high for 1 cycle: rise and fall both seen; still launches.
//    Start high at reset release: no rise is detected until it falls and rises again.
//  AllDone clears only on Reset. Further pulses after AllDone produce no PCLoad.
//  Reset mid-operation (any state) aborts immediately: Run=0, PCLoad=0, ProgIdx=0.
//  Width: ProgIdx increments modulo 4, but the guard above prevents it exceeding NUM_PROGS.
// CONFIGURATION
//  `PLC_CYCLE_COUNT_EN defined:
//    CycleCount clears to 0 on the LOAD cycle.
//    Increments by 1 in every RUN cycle and saturates at all-ones.
//    Holds in FIN, IDLE and ARMED.
//  Not defined: CycleCount is tied to 0 and no counter register is built. The port always exists.
// TESTING
//  T1 reset: assert Reset async mid-cycle -> all outputs 0 immediately; PC held (Run=0).
//  T2 launch 1: Start high 3 cycles then low -> ProgIdx=1.
//     PCLoad 1 cycle with PCLoadAddr=0, then Run=1.
//     Done after 10 Run cycles -> Run=0; CycleCount=10 (macro on) or 0 (off).
//  T3 launches 2 and 3: PCLoadAddr=190 then 639.
//     After 3rd Done -> AllDone=1; a 4th pulse gives no PCLoad and ProgIdx stays 3.
//  T4 Start pulsed twice during RUN -> no state change; next IDLE pulse launches program 2.
//  T5 Done held high before launch -> RUN lasts 1 cycle; CycleCount=1 (macro on).
//  T6 Reset asserted in RUN of program 2 -> Run=0, ProgIdx=0; next pulse loads address 0.

Source files
------------

// File: rtl/prog_launch_ctrl.sv
// =============================================================================
// prog_launch_ctrl
// -----------------------------------------------------------------------------
// Purpose:
//   Sequencer in front of the program counter. Counts Start pulses and loads
//   the entry address of program 1..NUM_PROGS into the PC. It holds the PC
//   while idle and enables it (Run) until the core reports Done. Then it
//   returns to idle and waits for the next pulse. A launch happens on the
//   falling edge of Start.
//
// Optional feature:
//   `PLC_CYCLE_COUNT_EN  when defined, CycleCount counts the Run cycles of the
//                        current/last program. It clears on LOAD, increments
//                        in every RUN cycle and saturates at all-ones.
//                        When undefined, CycleCount is tied to 0 and no
//                        counter register is built.
//
// Ports:
//   Clk         in   1      clock, all state changes on posedge
//   Reset       in   1      asynchronous, active-high reset
//   Start       in   1      launch strobe (level); launch on its falling edge
//   Done        in   1      current program finished; sampled only in RUN
//   PCLoad      out  1      one-cycle pulse: PC <= PCLoadAddr
//   PCLoadAddr  out  L      entry address of the current program
//   Run         out  1      PC/core enable; PC holds while 0
//   ProgIdx     out  2      program launched (0 = none yet, then 1..NUM_PROGS)
//   Busy        out  1      high in LOAD, RUN and FIN
//   AllDone     out  1      sticky: program NUM_PROGS has finished
//   CycleCount  out  CYC_W  Run cycles of the current/last program
// =============================================================================
module prog_launch_ctrl #(
   parameter int L          = 10,
   parameter int NUM_PROGS  = 3,
   parameter int PROG1_ADDR = 0,
   parameter int PROG2_ADDR = 190,
   parameter int PROG3_ADDR = 639,
   parameter int CYC_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Done,
   output logic             PCLoad,
   output logic [L-1:0]     PCLoadAddr,
   output logic             Run,
   output logic [1:0]       ProgIdx,
   output logic             Busy,
   output logic             AllDone,
   output logic [CYC_W-1:0] CycleCount
);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      LOAD,
      RUN,
      FIN
   } state_t;

   localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS);

   state_t       state;
   state_t       next_state;
   logic         start_r;
   logic         start_low_seen;
   logic         rise;
   logic         fall;
   logic         launch;
   logic         pc_load_d;
   logic         run_d;
   logic         busy_d;
   logic [L-1:0] entry_addr;

   // Start must be seen low once after reset before a rise can count. If
   // Start is already high when reset releases, that level is not a launch.
   assign rise   = Start & ~start_r & start_low_seen;
   assign fall   = ~Start & start_r;
   assign launch = (state == IDLE) && rise && (ProgIdx < LAST_IDX);

   // Entry address of the program just armed. Index 0 and indices above
   // NUM_PROGS select 0.
   always_comb begin
      // NOTE: give every combinationally assigned signal a default first.
      // Any path that leaves it unassigned would infer a latch.
      entry_addr = '0;
      case (ProgIdx)
         2'd1:    if (NUM_PROGS >= 1) entry_addr = L'(PROG1_ADDR);
         2'd2:    if (NUM_PROGS >= 2) entry_addr = L'(PROG2_ADDR);
         2'd3:    if (NUM_PROGS >= 3) entry_addr = L'(PROG3_ADDR);
         default: entry_addr = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // State register plus registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state          <= IDLE;
         start_r        <= 1'b0;
         start_low_seen <= 1'b0;
         PCLoad         <= 1'b0;
         Run            <= 1'b0;
         Busy           <= 1'b0;
         ProgIdx        <= 2'd0;
         PCLoadAddr     <= '0;
         AllDone        <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // register here sees the values from before this clock edge.
         state   <= next_state;
         start_r <= Start;
         if (!Start) start_low_seen <= 1'b1;

         // Outputs are decoded from next_state and registered. They change
         // together with the state and never glitch.
         PCLoad <= pc_load_d;
         Run    <= run_d;
         Busy   <= busy_d;

         if (launch) ProgIdx <= ProgIdx + 2'd1;
         if (state == ARMED) PCLoadAddr <= entry_addr;
         if (state == FIN && ProgIdx == LAST_IDX) AllDone <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (launch) next_state = ARMED;
         ARMED:   if (fall)   next_state = LOAD;
         LOAD:    next_state = RUN;
         RUN:     if (Done)   next_state = FIN;
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode (Moore, registered above)
   // ------------------------------------------------------------------
   always_comb begin
      pc_load_d = (next_state == LOAD);
      run_d     = (next_state == RUN);
      busy_d    = (next_state == LOAD) || (next_state == RUN) ||
                  (next_state == FIN);
   end

   // ------------------------------------------------------------------
   // Run-cycle counter
   // ------------------------------------------------------------------
`ifdef PLC_CYCLE_COUNT_EN
   logic [CYC_W-1:0] cycle_cnt;

   // The counter follows next_state, so it reads 0 in the LOAD cycle and
   // n in the n-th RUN cycle. It holds in FIN, IDLE and ARMED.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cycle_cnt <= '0;
      end else if (next_state == LOAD) begin
         cycle_cnt <= '0;
      end else if (next_state == RUN && cycle_cnt != '1) begin
         cycle_cnt <= cycle_cnt + 1'b1;
      end
   end

   assign CycleCount = cycle_cnt;
`else
   assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_prog_launch_ctrl.sv
// =============================================================================
// tb_prog_launch_ctrl
// Testbench for prog_launch_ctrl. The reference model works at the level of
// launches: a launched-program counter, an entry-address table and the
// expected Run length. Inputs change 1 time unit after the rising edge, and
// outputs are sampled at the same point.
// =============================================================================
module tb_prog_launch_ctrl;

   localparam int L     = 10;
   localparam int NUM   = 3;
   localparam int CYC_W = 16;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             Start;
   logic             Done;
   logic             PCLoad;
   logic [L-1:0]     PCLoadAddr;
   logic             Run;
   logic [1:0]       ProgIdx;
   logic             Busy;
   logic             AllDone;
   logic [CYC_W-1:0] CycleCount;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int model_idx;
   bit model_all;
   int addr_tab [4] = '{0, 0, 190, 639};   // indexed by program number
   int last_cyc;                           // expected CycleCount value

   prog_launch_ctrl #(
      .L(L), .NUM_PROGS(NUM), .PROG1_ADDR(0), .PROG2_ADDR(190),
      .PROG3_ADDR(639), .CYC_W(CYC_W)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done),
      .PCLoad(PCLoad), .PCLoadAddr(PCLoadAddr), .Run(Run),
      .ProgIdx(ProgIdx), .Busy(Busy), .AllDone(AllDone),
      .CycleCount(CycleCount)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_cyc(input int n);
`ifdef PLC_CYCLE_COUNT_EN
      return (n > (1 << CYC_W) - 1) ? (1 << CYC_W) - 1 : n;
`else
      return 0;
`endif
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pcload"},  PCLoad, 0);
      check({tag, "_addr"},    PCLoadAddr, 0);
      check({tag, "_run"},     Run, 0);
      check({tag, "_idx"},     ProgIdx, 0);
      check({tag, "_busy"},    Busy, 0);
      check({tag, "_alldone"}, AllDone, 0);
      check({tag, "_cyc"},     CycleCount, 0);
   endtask

   // Reset the DUT and the model. Start stays low through one sampled edge
   // after release, so the next rise is seen.
   task automatic do_reset();
      Start = 1'b0;
      Done  = 1'b0;
      Reset = 1'b1;
      #1;
      check_all_zero("rst");
      step();
      Reset = 1'b0;
      step();
      model_idx = 0;
      model_all = 1'b0;
      last_cyc  = 0;
   endtask

   // One Start pulse of hi cycles, then a program of run_len Run cycles.
   // pulses toggles Start during RUN. pre_done holds Done high from the
   // start. abort_at > 0 asserts Reset mid-cycle after that many Run cycles.
   task automatic run_program(input int hi, input int run_len, input bit pulses,
                              input bit pre_done, input int abort_at);
      bit will_launch;
      will_launch = (model_idx < NUM);
      if (pre_done) Done = 1'b1;
      Start = 1'b1;
      repeat (hi) step();
      Start = 1'b0;
      step();
      check("pcload", PCLoad, will_launch);
      if (!will_launch) begin
         check("idx_hold", ProgIdx, model_idx);
         check("busy_idle", Busy, 0);
         check("alldone_sticky", AllDone, model_all);
         step();
         check("no_run", Run, 0);
         check("no_pcload", PCLoad, 0);
         Done = 1'b0;
         return;
      end
      model_idx++;
      check("idx", ProgIdx, model_idx);
      check("addr", PCLoadAddr, addr_tab[model_idx]);
      check("run_in_load", Run, 0);
      check("busy_load", Busy, 1);
      step();
      check("run_start", Run, 1);
      check("pcload_off", PCLoad, 0);
      for (int i = 1; i < run_len; i++) begin
         if (abort_at == i) begin
            #2;
            Reset = 1'b1;
            #1;
            check_all_zero("abort");
            Start = 1'b0;
            Done  = 1'b0;
            step();
            Reset = 1'b0;
            step();
            model_idx = 0;
            model_all = 1'b0;
            last_cyc  = 0;
            return;
         end
         if (pulses) Start = i[0];
         step();
         check("run_hold", Run, 1);
         check("idx_run", ProgIdx, model_idx);
      end
      Start = 1'b0;
      Done  = 1'b1;
      step();
      last_cyc = exp_cyc(run_len);
      check("run_fin", Run, 0);
      check("busy_fin", Busy, 1);
      check("cyc", CycleCount, last_cyc);
      check("alldone_fin", AllDone, model_all);
      Done = 1'b0;
      step();
      if (model_idx == NUM) model_all = 1'b1;
      check("busy_idle", Busy, 0);
      check("run_idle", Run, 0);
      check("alldone", AllDone, model_all);
      check("cyc_hold", CycleCount, last_cyc);
   endtask

   initial begin
      Reset = 1'b1;
      Start = 1'b0;
      Done  = 1'b0;
      #1;
      check_all_zero("por");
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      step();
      model_idx = 0;
      model_all = 1'b0;
      last_cyc  = 0;

      // First launch: Start high 3 cycles, 10 Run cycles
      run_program(3, 10, 1'b0, 1'b0, 0);

      // Reset mid-cycle during RUN of program 2
      run_program(int'($urandom_range(1, 4)), 12, 1'b0, 1'b0, 5);

      // Start high at reset release: no launch until it falls and rises
      Start = 1'b1;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      repeat (3) step();
      check("hi_at_release_busy", Busy, 0);
      check("hi_at_release_idx", ProgIdx, 0);
      Start = 1'b0;
      step();
      check("hi_at_release_fall", Busy, 0);
      check("hi_at_release_pcload", PCLoad, 0);

      // Program 1 with a one-cycle Start pulse
      run_program(1, int'($urandom_range(2, 15)), 1'b0, 1'b0, 0);
      // Program 2 with Start pulsed during RUN
      run_program(2, 8, 1'b1, 1'b0, 0);
      // Program 3 with Done already high: one Run cycle, then AllDone
      run_program(2, 1, 1'b0, 1'b1, 0);
      // Extra pulses after AllDone launch nothing
      run_program(2, 5, 1'b0, 1'b0, 0);
      run_program(1, 5, 1'b0, 1'b0, 0);

      // Randomized rounds
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int k = 0; k < NUM + 1; k++) begin
            int hi;
            int rl;
            bit pd;
            bit pl;
            int ab;
            hi = int'($urandom_range(1, 4));
            pd = ($urandom_range(0, 3) == 0);
            rl = pd ? 1 : int'($urandom_range(1, 30));
            pl = $urandom_range(0, 1) == 1;
            ab = 0;
            if (r[0] && rl > 2 && $urandom_range(0, 4) == 0)
               ab = int'($urandom_range(1, rl - 1));
            run_program(hi, rl, pl, pd, ab);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
